bridge_arbiter: RTL
===================

BRIDGE_ARBITER -- requirements
Module: bridge_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of flit buffers sharing one bridge master, range 1..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: maximum WAIT-state cycles before abort; 0 disables the timeout.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port res_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port req_avail_i, input, NUM_PORTS: per-buffer data_to_bridge_avail.
REQ-006 Port req_taken_o, output, NUM_PORTS: per-buffer data_to_bridge_taken, one-cycle pulse.
REQ-007 Port req_data_i, input, NUM_PORTS*`MERGED_REQUEST_WIDTH: per-buffer merged request; port k occupies slice k.
REQ-008 Port resp_avail_o, output, NUM_PORTS: per-buffer data_from_bridge_avail.
REQ-009 Port resp_taken_i, input, NUM_PORTS: per-buffer data_from_bridge_taken.
REQ-010 Port resp_data_o, output, `MERGED_REQUEST_WIDTH: response, broadcast to all buffers.
REQ-011 Ports br_req_avail_o (out, 1), br_req_taken_i (in, 1), br_req_data_o (out, `MERGED_REQUEST_WIDTH): request side toward the bridge.
REQ-012 Ports br_resp_avail_i (in, 1), br_resp_taken_o (out, 1), br_resp_data_i (in, `MERGED_REQUEST_WIDTH): response side from the bridge.
REQ-013 Port grant_o, output, NUM_PORTS: one-hot owner of the current transaction, all-zero when idle.
REQ-014 Port timeout_o, output, 1: one-cycle pulse when a transaction is aborted.

Function
REQ-015 All outputs are registered, and states are IDLE, FWD, WAIT and RET.
REQ-016 IDLE: scan req_avail_i from rr_ptr upward with wrap; on the first set bit k, latch slice k, set grant_o to one-hot k, pulse req_taken_o[k] for one cycle and go to FWD; if no bit is set, stay in IDLE.
REQ-017 FWD: br_req_avail_o=1 and br_req_data_o=latched request; when br_req_taken_i=1 is sampled, drop br_req_avail_o next cycle, clear the timer and go to WAIT.
REQ-018 WAIT: when br_resp_avail_i=1, latch br_resp_data_i, pulse br_resp_taken_o for one cycle and go to RET; otherwise increment the timer.
REQ-019 WAIT timeout: when TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1 with no response, pulse timeout_o, clear grant_o, set rr_ptr=(k+1) mod NUM_PORTS and go to IDLE.
REQ-020 RET: resp_avail_o[k]=1 and resp_data_o=latched response; when resp_taken_i[k]=1, clear resp_avail_o and grant_o, set rr_ptr=(k+1) mod NUM_PORTS and go to IDLE.
REQ-021 Minimum round trip: grant 1 cycle, bridge accept 1 cycle or more, response 1 cycle or more, return 1 cycle or more; a back-to-back grant occurs in the cycle after RET exits.
REQ-022 resp_taken_i bits of non-granted ports are ignored.
REQ-023 br_resp_avail_i outside WAIT is ignored.
REQ-024 br_req_taken_i outside FWD is ignored.
REQ-025 Simultaneous requests are resolved round-robin from rr_ptr; a port is never granted twice while another port has held req_avail_i through a full rotation.
REQ-026 At most one resp_avail_o bit and at most one grant_o bit are set at any time.
REQ-027 The timer width is clog2(TIMEOUT_CYCLES+1) and the timer saturates rather than wraps.

Reset
REQ-028 res_n=0 asynchronously forces state=IDLE, rr_ptr=0, timer=0 and every output to 0, including the data buses.
REQ-029 Reset asserted mid-transaction drops the transaction silently, with no pulse on any taken or timeout output.
REQ-030 After res_n deasserts, the first grant is possible on the second rising edge.

Structure
REQ-031 `MERGED_REQUEST_WIDTH comes from the shared defines header.
REQ-032 The state enum and the TIMEOUT_CYCLES default live in package bridge_arb_pkg.
REQ-033 Round-robin selection is the combinational sub-module rr_pick (inputs: request vector and pointer; outputs: valid and index).

Verification
REQ-034 Single request: port 1 avail, data 0xA5 pattern, bridge takes after 3 cycles and responds 0x5A 4 cycles later -> req_taken_o=2'b10 pulse; br_req_data_o=0xA5; resp_avail_o[1] holding 0x5A until resp_taken_i[1].
REQ-035 Contention: ports 0 and 1 request continuously with NUM_PORTS=2 -> grant order 0,1,0,1, with no port starved.
REQ-036 Timeout: TIMEOUT_CYCLES=8 and the bridge never responds -> timeout_o pulses exactly 8 cycles after WAIT entry, then grant_o=0 and the next port is granted.
REQ-037 Stray signals: br_resp_avail_i pulsed in IDLE and resp_taken_i[0] pulsed while port 1 owns RET -> no state change and no outputs.
REQ-038 Reset in WAIT: res_n low for 1 cycle -> all outputs 0 immediately, with no timeout_o pulse; a new request completes normally afterwards.
REQ-039 Wrap: NUM_PORTS=4, rr_ptr=3, requests on ports 0 and 2 -> port 0 granted first, then port 2.

Source files
------------

// File: rtl/bridge_arbiter_pkg.sv
// bridge_arb_pkg: shared defines, state encoding and constants for the bridge arbiter.
// Provides MERGED_REQUEST_WIDTH (shared defines), MRW, DEFAULT_TIMEOUT_CYCLES,
// the arbiter state enum and a pointer-width helper.
`ifndef MERGED_REQUEST_WIDTH
`define MERGED_REQUEST_WIDTH 64
`endif

package bridge_arb_pkg;

    localparam int MRW = `MERGED_REQUEST_WIDTH;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_WAIT,
        ST_RET
    } arb_state_e;

    // A single port still needs a one-bit pointer/index.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bridge_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports: req_i (request vector), ptr_i (search start), valid_o (any request), idx_o (winner).
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic          valid_o,
    output logic [PW-1:0] idx_o
);

    logic [PW-1:0] j;

    // Walk offsets from farthest to nearest so the port closest to ptr_i wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        j       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = PW'((int'(ptr_i) + i) % N);
            if (req_i[j]) begin
                valid_o = 1'b1;
                idx_o   = j;
            end
        end
    end

endmodule

// File: rtl/bridge_arbiter.sv
// bridge_arbiter: shares one bridge master among NUM_PORTS flit buffers, round-robin.
// Ports: clk/res_n; per-buffer req_avail_i/req_taken_o/req_data_i and
// resp_avail_o/resp_taken_i with broadcast resp_data_o; bridge request side
// br_req_*; bridge response side br_resp_*; grant_o (one-hot owner); timeout_o (abort pulse).
module bridge_arbiter
    import bridge_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic [NUM_PORTS-1:0]     req_avail_i,
    output logic [NUM_PORTS-1:0]     req_taken_o,
    input  logic [NUM_PORTS*MRW-1:0] req_data_i,
    output logic [NUM_PORTS-1:0]     resp_avail_o,
    input  logic [NUM_PORTS-1:0]     resp_taken_i,
    output logic [MRW-1:0]           resp_data_o,
    output logic                     br_req_avail_o,
    input  logic                     br_req_taken_i,
    output logic [MRW-1:0]           br_req_data_o,
    input  logic                     br_resp_avail_i,
    output logic                     br_resp_taken_o,
    input  logic [MRW-1:0]           br_resp_data_i,
    output logic [NUM_PORTS-1:0]     grant_o,
    output logic                     timeout_o
);

    localparam int PW = ptr_w(NUM_PORTS);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);

    arb_state_e           state_q;
    logic                 ready_q;
    logic [PW-1:0]        rr_ptr_q, own_q, pick_idx, next_ptr;
    logic                 pick_valid;
    logic [TW-1:0]        timer_q;
    logic [NUM_PORTS-1:0] req_taken_q, resp_avail_q, grant_q, pick_oh;
    logic [MRW-1:0]       resp_data_q, br_req_data_q;
    logic                 br_req_avail_q, br_resp_taken_q, timeout_q;

    rr_pick #(.N(NUM_PORTS), .PW(PW)) u_pick (
        .req_i   (req_avail_i),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign pick_oh  = NUM_PORTS'(1) << pick_idx;
    assign next_ptr = (own_q == LAST) ? '0 : own_q + 1'b1;

    // ready_q holds off arbitration for the first edge after reset release.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q         <= ST_IDLE;
            ready_q         <= 1'b0;
            rr_ptr_q        <= '0;
            own_q           <= '0;
            timer_q         <= '0;
            req_taken_q     <= '0;
            resp_avail_q    <= '0;
            grant_q         <= '0;
            resp_data_q     <= '0;
            br_req_data_q   <= '0;
            br_req_avail_q  <= 1'b0;
            br_resp_taken_q <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            ready_q         <= 1'b1;
            req_taken_q     <= '0;
            br_resp_taken_q <= 1'b0;
            timeout_q       <= 1'b0;
            case (state_q)
                ST_IDLE: if (ready_q && pick_valid) begin
                    own_q          <= pick_idx;
                    grant_q        <= pick_oh;
                    req_taken_q    <= pick_oh;
                    br_req_data_q  <= req_data_i[int'(pick_idx)*MRW +: MRW];
                    br_req_avail_q <= 1'b1;
                    state_q        <= ST_FWD;
                end
                ST_FWD: if (br_req_taken_i) begin
                    br_req_avail_q <= 1'b0;
                    timer_q        <= '0;
                    state_q        <= ST_WAIT;
                end
                ST_WAIT: if (br_resp_avail_i) begin
                    resp_data_q     <= br_resp_data_i;
                    br_resp_taken_q <= 1'b1;
                    resp_avail_q    <= grant_q;
                    state_q         <= ST_RET;
                end else if (TIMEOUT_CYCLES != 0 && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_q <= 1'b1;
                    grant_q   <= '0;
                    rr_ptr_q  <= next_ptr;
                    state_q   <= ST_IDLE;
                end else if (timer_q != '1) begin
                    timer_q <= timer_q + 1'b1;
                end
                ST_RET: if (resp_taken_i[own_q]) begin
                    resp_avail_q <= '0;
                    grant_q      <= '0;
                    rr_ptr_q     <= next_ptr;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_taken_o     = req_taken_q;
    assign resp_avail_o    = resp_avail_q;
    assign resp_data_o     = resp_data_q;
    assign grant_o         = grant_q;
    assign br_req_avail_o  = br_req_avail_q;
    assign br_req_data_o   = br_req_data_q;
    assign br_resp_taken_o = br_resp_taken_q;
    assign timeout_o       = timeout_q;

endmodule
